// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - runs the Convolution2D engine once per output filter of a layer
// Optional watchdog on each engine run: define SCHED_TIMEOUT_EN.
module conv_layer_scheduler #(
  parameter int ADDR_W         = 14,
  parameter int IMG_SIZE       = 48,
  parameter int KERNEL_SIZE    = 3,
  parameter int KERNEL_STRIDE  = KERNEL_SIZE * KERNEL_SIZE,
  parameter int RESULT_STRIDE  = (IMG_SIZE - KERNEL_SIZE + 1) * (IMG_SIZE - KERNEL_SIZE + 1),
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        n_filters,
  input  logic [ADDR_W-1:0] pix_base_addr,
  input  logic [ADDR_W-1:0] kernel_base_addr,
  input  logic [ADDR_W-1:0] result_base_addr,
  input  logic              conv_completed,
  output logic              conv_en,
  output logic [ADDR_W-1:0] conv_pix_base,
  output logic [ADDR_W-1:0] conv_kernel_base,
  output logic [ADDR_W-1:0] conv_result_base,
  output logic [7:0]        filter_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, SETUP, RUN, FIN} state_t;

  localparam logic [ADDR_W-1:0] K_STEP = ADDR_W'(KERNEL_STRIDE);
  localparam logic [ADDR_W-1:0] R_STEP = ADDR_W'(RESULT_STRIDE);

  state_t     state;
  logic [7:0] n_lat;
  logic       last_filter;

  assign last_filter = (filter_idx == n_lat - 8'd1);

`ifdef SCHED_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wdog;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      n_lat            <= 8'd0;
      conv_en          <= 1'b0;
      conv_pix_base    <= '0;
      conv_kernel_base <= '0;
      conv_result_base <= '0;
      filter_idx       <= 8'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wdog             <= 16'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            err              <= 1'b0;
            busy             <= 1'b1;
            n_lat            <= n_filters;
            filter_idx       <= 8'd0;
            conv_pix_base    <= pix_base_addr;
            conv_kernel_base <= kernel_base_addr;
            conv_result_base <= result_base_addr;
            if (n_filters == 8'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= SETUP;
            end
          end
        end
        SETUP: begin
          // One cycle with conv_en low lets the engine re-arm on the new bases.
          state   <= RUN;
          conv_en <= 1'b1;
`ifdef SCHED_TIMEOUT_EN
          wdog    <= 16'd0;
`endif
        end
        RUN: begin
          if (conv_completed) begin
            conv_en <= 1'b0;
            if (last_filter) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              filter_idx       <= filter_idx + 8'd1;
              conv_kernel_base <= conv_kernel_base + K_STEP;
              conv_result_base <= conv_result_base + R_STEP;
              state            <= SETUP;
            end
          end
`ifdef SCHED_TIMEOUT_EN
          else if (wdog == WDOG_LAST) begin
            err     <= 1'b1;
            conv_en <= 1'b0;
            state   <= FIN;
            done    <= 1'b1;
          end else begin
            wdog <= wdog + 16'd1;
          end
`endif
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SCHED_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule
